// File: rtl/atm_pkg.sv
// atm_pkg: definitions shared by the ATM session controller and its timeout counter.
//   state_t      session FSM states
//   OP_*         op_code encodings
//   ERR_*        err_code encodings
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AUTH_WAIT,
        VERIFY,
        RESULT,
        MENU,
        COMMIT,
        EJECT,
        WAIT_REMOVE
    } state_t;

    localparam logic [1:0] OP_QUERY    = 2'b00;
    localparam logic [1:0] OP_WITHDRAW = 2'b01;
    localparam logic [1:0] OP_DEPOSIT  = 2'b10;
    localparam logic [1:0] OP_EXIT     = 2'b11;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_CARD     = 3'd1;
    localparam logic [2:0] ERR_PIN      = 3'd2;
    localparam logic [2:0] ERR_LOCKED   = 3'd3;
    localparam logic [2:0] ERR_FUNDS    = 3'd4;
    localparam logic [2:0] ERR_OVERFLOW = 3'd5;

endpackage

// File: rtl/atm_timeout.sv
// atm_timeout: idle watchdog as a reloadable down-counter.
//   clk, rst   clock, synchronous active-high reset
//   en_i       count only while the session is waiting on the user
//   clr_i      user strobe seen; restart the idle window
//   expire_o   high in the cycle the window is used up (cycles-th idle cycle)
// The "cleared" value of a down-counter is the reload value, so reset,
// clear and disable all reload it.
module atm_timeout #(
    parameter int cycles = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int            TW   = (cycles > 2) ? $clog2(cycles) : 1;
    localparam logic [TW-1:0] LOAD = TW'(cycles - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i || !en_i) begin
            cnt_q <= LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: card/PIN/transaction session FSM in front of a card handler.
//   card_inserted/card_id     card slot
//   pin_valid/pin             PIN entry strobe
//   op_valid/op_code/amount   transaction strobe
//   balance/wrong_psw         registered answers from the card handler
//   card_number/card_in/password_input   session info toward the card handler
//   op_done/updated_balance   one-cycle commit of the new balance
//   balance_out/err_code      user display
//   eject/busy                card eject pulse, session activity
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int card_width     = 3,
    parameter int password_width = 16,
    parameter int balance_width  = 20,
    parameter int users_num      = 8,
    parameter int max_attempts   = 3,
    parameter int timeout_cycles = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      card_inserted,
    input  logic [card_width-1:0]     card_id,
    input  logic                      pin_valid,
    input  logic [password_width-1:0] pin,
    input  logic                      op_valid,
    input  logic [1:0]                op_code,
    input  logic [balance_width-1:0]  amount,
    input  logic [balance_width-1:0]  balance,
    input  logic                      wrong_psw,
    output logic [card_width-1:0]     card_number,
    output logic                      card_in,
    output logic [password_width-1:0] password_input,
    output logic                      op_done,
    output logic [balance_width-1:0]  updated_balance,
    output logic [balance_width-1:0]  balance_out,
    output logic [2:0]                err_code,
    output logic                      eject,
    output logic                      busy
);
    localparam int                    AW      = $clog2(max_attempts + 1);
    localparam logic [AW-1:0]         MAX_ATT = AW'(max_attempts);
    localparam logic [card_width:0]   USERS   = (card_width + 1)'(users_num);

    state_t                    state_q, state_d;
    logic [card_width-1:0]     card_q, card_d;
    logic [password_width-1:0] pwd_q, pwd_d;
    logic [balance_width-1:0]  bal_q, bal_d;        // session balance
    logic [balance_width-1:0]  new_q, new_d;        // balance pending commit
    logic [balance_width-1:0]  bal_out_q, bal_out_d;
    logic [2:0]                err_q, err_d;
    logic [AW-1:0]             att_q, att_d;
    logic [users_num-1:0]      lock_q, lock_d;

    logic                      tmo_en, tmo_expire;
    logic [balance_width:0]    dep_sum;

    assign tmo_en  = (state_q == AUTH_WAIT) || (state_q == MENU);
    assign dep_sum = {1'b0, bal_q} + {1'b0, amount};

    atm_timeout #(.cycles(timeout_cycles)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .en_i     (tmo_en),
        .clr_i    (pin_valid || op_valid),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            card_q    <= '0;
            pwd_q     <= '0;
            bal_q     <= '0;
            new_q     <= '0;
            bal_out_q <= '0;
            err_q     <= ERR_NONE;
            att_q     <= '0;
            lock_q    <= '0;
        end else begin
            state_q   <= state_d;
            card_q    <= card_d;
            pwd_q     <= pwd_d;
            bal_q     <= bal_d;
            new_q     <= new_d;
            bal_out_q <= bal_out_d;
            err_q     <= err_d;
            att_q     <= att_d;
            lock_q    <= lock_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        card_d    = card_q;
        pwd_d     = pwd_q;
        bal_d     = bal_q;
        new_d     = new_q;
        bal_out_d = bal_out_q;
        err_d     = err_q;
        att_d     = att_q;
        lock_d    = lock_q;
        case (state_q)
            IDLE: if (card_inserted) begin
                if ({1'b0, card_id} >= USERS) begin
                    err_d   = ERR_CARD;
                    state_d = EJECT;
                end else if (lock_q[card_id]) begin
                    err_d   = ERR_LOCKED;
                    state_d = EJECT;
                end else begin
                    // fresh session: nothing from the previous card stays visible
                    card_d    = card_id;
                    att_d     = '0;
                    err_d     = ERR_NONE;
                    bal_d     = '0;
                    bal_out_d = '0;
                    state_d   = AUTH_WAIT;
                end
            end
            AUTH_WAIT: begin
                if (!card_inserted || tmo_expire) begin
                    state_d = EJECT;
                end else if (pin_valid) begin
                    pwd_d   = pin;
                    err_d   = ERR_NONE;
                    state_d = VERIFY;
                end
            end
            // card handler needs this cycle to answer the latched PIN
            VERIFY: state_d = card_inserted ? RESULT : EJECT;
            RESULT: begin
                if (!card_inserted) begin
                    state_d = EJECT;
                end else if (wrong_psw) begin
                    att_d = att_q + AW'(1);
                    if (att_d == MAX_ATT) begin
                        lock_d[card_q] = 1'b1;
                        err_d          = ERR_LOCKED;
                        state_d        = EJECT;
                    end else begin
                        err_d   = ERR_PIN;
                        state_d = AUTH_WAIT;
                    end
                end else begin
                    bal_d   = balance;
                    err_d   = ERR_NONE;
                    state_d = MENU;
                end
            end
            MENU: begin
                if (!card_inserted || tmo_expire) begin
                    state_d = EJECT;
                end else if (op_valid) begin
                    err_d = ERR_NONE;
                    case (op_code)
                        OP_QUERY: bal_out_d = bal_q;
                        OP_WITHDRAW: begin
                            if (amount > bal_q) begin
                                err_d = ERR_FUNDS;
                            end else begin
                                new_d   = bal_q - amount;
                                state_d = COMMIT;
                            end
                        end
                        OP_DEPOSIT: begin
                            if (dep_sum[balance_width]) begin
                                err_d = ERR_OVERFLOW;
                            end else begin
                                new_d   = dep_sum[balance_width-1:0];
                                state_d = COMMIT;
                            end
                        end
                        default: state_d = EJECT;
                    endcase
                end
            end
            // commit always completes; a pulled card only redirects the next state
            COMMIT: begin
                bal_d     = new_q;
                bal_out_d = new_q;
                err_d     = ERR_NONE;
                state_d   = card_inserted ? MENU : EJECT;
            end
            EJECT: state_d = WAIT_REMOVE;
            WAIT_REMOVE: if (!card_inserted) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign card_number     = card_q;
    assign password_input  = pwd_q;
    assign balance_out     = bal_out_q;
    assign err_code        = err_q;
    assign card_in         = (state_q == AUTH_WAIT) || (state_q == VERIFY) ||
                             (state_q == RESULT) || (state_q == MENU) || (state_q == COMMIT);
    assign op_done         = (state_q == COMMIT);
    assign eject           = (state_q == EJECT);
    assign busy            = (state_q != IDLE);
    assign updated_balance = (state_q == COMMIT) ? new_q : bal_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
module tb_atm_session_ctrl;
    logic        clk = 1'b0;
    logic        rst, card_inserted, pin_valid, op_valid, wrong_psw;
    logic [2:0]  card_id;
    logic [15:0] pin;
    logic [1:0]  op_code;
    logic [19:0] amount, balance;
    logic [2:0]  card_number;
    logic        card_in, op_done, eject, busy;
    logic [15:0] password_input;
    logic [19:0] updated_balance, balance_out;
    logic [2:0]  err_code;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int eject_cnt = 0;
    int d0, e0;

    atm_session_ctrl #(.users_num(6)) dut (
        .clk(clk), .rst(rst), .card_inserted(card_inserted), .card_id(card_id),
        .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid), .op_code(op_code),
        .amount(amount), .balance(balance), .wrong_psw(wrong_psw),
        .card_number(card_number), .card_in(card_in), .password_input(password_input),
        .op_done(op_done), .updated_balance(updated_balance), .balance_out(balance_out),
        .err_code(err_code), .eject(eject), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (op_done) done_cnt++;
        if (eject)   eject_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_card_number"}, 32'(card_number), 0);
        chk({tag, "_card_in"}, 32'(card_in), 0);
        chk({tag, "_password"}, 32'(password_input), 0);
        chk({tag, "_op_done"}, 32'(op_done), 0);
        chk({tag, "_updated"}, 32'(updated_balance), 0);
        chk({tag, "_bal_out"}, 32'(balance_out), 0);
        chk({tag, "_err"}, 32'(err_code), 0);
        chk({tag, "_eject"}, 32'(eject), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic insert(input logic [2:0] id);
        card_id = id;
        card_inserted = 1'b1;
        tick();
    endtask

    // PIN strobe, then VERIFY and RESULT; returns after the RESULT decision edge
    task automatic enter_pin(input logic [15:0] p);
        pin = p;
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic op(input logic [1:0] code, input logic [19:0] amt);
        op_valid = 1'b1;
        op_code = code;
        amount = amt;
        tick();
        op_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; card_inserted = 1'b0; card_id = '0; pin_valid = 1'b0; pin = '0;
        op_valid = 1'b0; op_code = '0; amount = '0; balance = '0; wrong_psw = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // card 2, good PIN, balance 1000
        balance = 20'd1000;
        insert(3'd2);
        chk("s2_card_in", 32'(card_in), 1);
        chk("s2_card_number", 32'(card_number), 2);
        chk("s2_busy", 32'(busy), 1);
        pin = 16'h1234; pin_valid = 1'b1; tick(); pin_valid = 1'b0;
        chk("s2_password", 32'(password_input), 32'h1234);
        tick(); tick();
        chk("s2_menu_updated", 32'(updated_balance), 1000);
        chk("s2_menu_err", 32'(err_code), 0);
        pin = 16'hBEEF; pin_valid = 1'b1; tick(); pin_valid = 1'b0;
        chk("s2_pin_ignored", 32'(password_input), 32'h1234);
        op(2'b01, 20'd1001);
        chk("wd_insuff_err", 32'(err_code), 4);
        chk("wd_insuff_done", 32'(op_done), 0);
        op(2'b10, 20'd1048000);
        chk("dep_ovf_err", 32'(err_code), 5);
        chk("dep_ovf_updated", 32'(updated_balance), 1000);
        chk("no_commit_cnt", 32'(done_cnt), 0);
        op(2'b01, 20'd300);
        chk("wd300_done", 32'(op_done), 1);
        chk("wd300_updated", 32'(updated_balance), 700);
        chk("wd300_err", 32'(err_code), 0);
        tick();
        chk("wd300_done_end", 32'(op_done), 0);
        chk("wd300_bal_out", 32'(balance_out), 700);
        chk("wd300_upd_hold", 32'(updated_balance), 700);
        chk("wd300_cnt", 32'(done_cnt), 1);
        op(2'b01, 20'd700);
        chk("wd_all_updated", 32'(updated_balance), 0);
        tick();
        chk("wd_all_bal_out", 32'(balance_out), 0);
        op(2'b10, 20'd50); tick();
        op(2'b00, 20'd0);
        chk("query_bal_out", 32'(balance_out), 50);
        chk("query_stay", 32'(card_in), 1);
        op(2'b11, 20'd0);
        chk("exit_eject", 32'(eject), 1);
        chk("exit_card_in", 32'(card_in), 0);
        tick();
        chk("exit_eject_pulse", 32'(eject), 0);
        tick();
        chk("wait_remove_busy", 32'(busy), 1);
        card_inserted = 1'b0; tick();
        chk("removed_busy", 32'(busy), 0);

        // card 5, wrong PIN three times -> lock
        wrong_psw = 1'b1;
        insert(3'd5);
        for (int i = 0; i < 3; i++) begin
            enter_pin(16'h0001);
            chk("bad_pin_err", 32'(err_code), (i < 2) ? 2 : 3);
            chk("bad_pin_eject", 32'(eject), (i < 2) ? 0 : 1);
        end
        tick();
        card_inserted = 1'b0; tick();
        insert(3'd5);
        chk("locked_eject", 32'(eject), 1);
        chk("locked_err", 32'(err_code), 3);
        chk("locked_card_in", 32'(card_in), 0);
        tick(); card_inserted = 1'b0; tick();
        wrong_psw = 1'b0;

        // invalid cards 7 and 6 (users_num = 6)
        insert(3'd7);
        chk("card7_err", 32'(err_code), 1);
        chk("card7_eject", 32'(eject), 1);
        tick(); card_inserted = 1'b0; tick();
        chk("card7_busy", 32'(busy), 0);
        insert(3'd6);
        chk("card6_err", 32'(err_code), 1);
        tick(); card_inserted = 1'b0; tick();

        // idle timeout in MENU
        balance = 20'd500;
        insert(3'd3);
        enter_pin(16'h0003);
        chk("tmo_menu_bal", 32'(updated_balance), 500);
        repeat (1023) tick();
        chk("tmo_not_yet", 32'(eject), 0);
        chk("tmo_still_menu", 32'(card_in), 1);
        tick();
        chk("tmo_eject", 32'(eject), 1);
        tick(); card_inserted = 1'b0; tick();

        // card pulled in AUTH_WAIT
        d0 = done_cnt;
        insert(3'd1);
        chk("pull_auth", 32'(card_in), 1);
        card_inserted = 1'b0; tick();
        chk("pull_eject", 32'(eject), 1);
        tick(); tick();
        chk("pull_idle", 32'(busy), 0);
        chk("pull_no_done", 32'(done_cnt), d0);

        // card pulled while COMMIT pending: commit still happens
        balance = 20'd1000;
        insert(3'd0);
        enter_pin(16'h0000);
        op(2'b01, 20'd200);
        chk("pull_commit_done", 32'(op_done), 1);
        chk("pull_commit_upd", 32'(updated_balance), 800);
        card_inserted = 1'b0; tick();
        chk("pull_commit_eject", 32'(eject), 1);
        chk("pull_commit_bal", 32'(balance_out), 800);
        tick(); tick();

        // reset on the edge that would enter COMMIT
        insert(3'd4);
        enter_pin(16'h0004);
        d0 = done_cnt; e0 = eject_cnt;
        op_valid = 1'b1; op_code = 2'b01; amount = 20'd100; rst = 1'b1;
        tick();
        op_valid = 1'b0; card_inserted = 1'b0;
        chk_all_zero("rst_commit");
        rst = 1'b0; tick();
        chk("rst_no_done", 32'(done_cnt), d0);
        chk("rst_no_eject", 32'(eject_cnt), e0);

        // reset cleared the lock on card 5
        insert(3'd5);
        chk("unlock_card_in", 32'(card_in), 1);
        chk("unlock_err", 32'(err_code), 0);
        card_inserted = 1'b0; tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/atm_session_ctrl.md
ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 Parameters SHALL be:
- card_width, 3, card number width.
- password_width, 16, PIN width.
- balance_width, 20, balance width.
- users_num, 8, number of valid cards.
- max_attempts, 3, wrong PINs before lock.
- timeout_cycles, 1024, idle cycles before forced eject.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- card_inserted  in  1  level, card present in slot.
- card_id  in  card_width  number of inserted card.
- pin_valid  in  1  one-cycle strobe, pin valid.
- pin  in  password_width  user-entered PIN.
- op_valid  in  1  one-cycle strobe, op_code/amount valid.
- op_code  in  2  00 query, 01 withdraw, 10 deposit, 11 exit.
- amount  in  balance_width  transaction amount.
- balance  in  balance_width  account balance from card handler, registered.
- wrong_psw  in  1  PIN-mismatch flag from card handler, registered.
- card_number  out  card_width  card presented to card handler.
- card_in  out  1  session active toward card handler.
- password_input  out  password_width  latched PIN toward card handler.
- op_done  out  1  one-cycle commit strobe.
- updated_balance  out  balance_width  balance to write back.
- balance_out  out  balance_width  balance shown to user.
- err_code  out  3  0 none, 1 invalid card, 2 wrong PIN, 3 locked, 4 insufficient funds, 5 overflow.
- eject  out  1  one-cycle card-eject pulse.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 FSM states SHALL be IDLE, AUTH_WAIT, VERIFY, RESULT, MENU, COMMIT, EJECT, WAIT_REMOVE.
REQ-004 IDLE, card_inserted=1: card_id>=users_num -> err=1, EJECT; lock[card_id]=1 -> err=3, EJECT; else latch card_id, clear attempts, -> AUTH_WAIT.
REQ-005 card_in SHALL be 1 in AUTH_WAIT, VERIFY, RESULT, MENU and COMMIT, and 0 otherwise.
REQ-006 AUTH_WAIT, pin_valid=1: latch pin into password_input, -> VERIFY.
REQ-007 VERIFY SHALL last exactly one cycle, then -> RESULT.
REQ-008 RESULT SHALL sample wrong_psw and balance, two cycles after pin_valid.
REQ-009 On a correct PIN, RESULT SHALL load the session balance register from balance, set err=0, -> MENU.
REQ-010 On a wrong PIN, RESULT SHALL increment attempts:
- attempts==max_attempts: set lock[card], err=3, -> EJECT.
- otherwise: err=2, -> AUTH_WAIT.
REQ-011 MENU, op_valid=1, by op_code:
- query: balance_out=session balance, stay in MENU.
- withdraw, amount>balance: err=4, no commit, stay in MENU.
- withdraw, amount<=balance: new=balance-amount, -> COMMIT.
- deposit, sum carries out of balance_width: err=5, no commit, stay in MENU.
- deposit, no carry: new=balance+amount, -> COMMIT.
- exit: -> EJECT.
REQ-012 Withdraw equal to balance is legal and SHALL yield 0.
REQ-013 COMMIT SHALL last one cycle:
- op_done=1, updated_balance=new.
- session balance and balance_out SHALL load new.
- err=0, -> MENU.
REQ-014 updated_balance SHALL equal the session balance register outside COMMIT.
REQ-015 The timeout counter SHALL run in AUTH_WAIT and MENU, clear on any pin_valid/op_valid or state change, and force EJECT when it reaches timeout_cycles-1.
REQ-016 card_inserted=0 in any session state SHALL abort to EJECT next cycle; a pending COMMIT in that cycle SHALL still complete first.
REQ-017 EJECT SHALL pulse eject for one cycle, then -> WAIT_REMOVE.
REQ-018 WAIT_REMOVE SHALL hold until card_inserted=0, then -> IDLE; this prevents re-entry without card removal.
REQ-019 err_code SHALL hold until the next user strobe or new session.
REQ-020 Strobes arriving in states that do not consume them SHALL be ignored.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE; clear attempts, timeout count and all lock bits; drive every output to 0.
REQ-022 Reset mid-session SHALL produce no op_done and no eject pulse.

Structure
REQ-023 Shared package atm_pkg SHALL hold the state enum, op_code constants and err_code constants.
REQ-024 Sub-module atm_timeout (parameterized down-counter, clear/enable/expire) SHALL implement REQ-015.

Verification
REQ-025 Card 2, correct PIN, balance 1000, withdraw 300 -> one op_done, updated_balance=700, balance_out=700.
REQ-026 Card 5, wrong PIN x3 -> err 2,2 then 3; eject pulse; reinserting card 5 -> err=3, immediate eject.
REQ-027 Balance 1000, withdraw 1001 -> err=4, no op_done; deposit 1048000 -> err=5, no op_done.
REQ-028 card_id=7 with users_num=6 -> err=1, eject, busy low after card removal.
REQ-029 MENU with no strobe for timeout_cycles -> eject; card pulled in AUTH_WAIT -> eject next cycle, no op_done.
REQ-030 rst asserted in COMMIT-1 cycle -> no op_done; all outputs 0 next cycle.
